// File: rtl/sketch_sram_update.sv
// Read-modify-write updater for an SRAM-resident sketch table, with a full-table clear sweep.
// Define SKETCH_PKT_CNT_EN to split each word into a 12-bit packet count and a byte count.
module sketch_sram_update #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [15:0]           upd_id,
  input  logic [15:0]           upd_bytes,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  sram_req,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic                  sram_gnt,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic                  sram_rvalid,
  output logic [31:0]           upd_count,
  output logic                  sat_flag
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_CLR
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           bytes_q, bytes_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic [31:0]           count_q, count_d;
  logic                  sat_q, sat_d;
  logic                  rst_done_q;

  logic [DATA_WIDTH-1:0] new_word;
  logic                  sat_hit;

  // Only the low ADDR_WIDTH bits of the hashed ID address the table.
  if (ADDR_WIDTH < 16) begin : g_id_unused
    logic unused_id_hi;
    assign unused_id_hi = ^upd_id[15:ADDR_WIDTH];
  end

`ifdef SKETCH_PKT_CNT_EN
  localparam int BW = DATA_WIDTH - 12;
  logic [12:0] pkt_sum;
  logic [BW:0] byte_sum;

  always_comb begin
    pkt_sum  = {1'b0, sram_rdata[DATA_WIDTH-1 -: 12]} + 13'd1;
    byte_sum = {1'b0, sram_rdata[BW-1:0]} + (BW+1)'(bytes_q);
    new_word = {(pkt_sum[12]  ? {12{1'b1}} : pkt_sum[11:0]),
                (byte_sum[BW] ? {BW{1'b1}} : byte_sum[BW-1:0])};
    sat_hit  = pkt_sum[12] | byte_sum[BW];
  end
`else
  logic [DATA_WIDTH:0] sum;

  always_comb begin
    sum      = {1'b0, sram_rdata} + (DATA_WIDTH+1)'(bytes_q);
    new_word = sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
    sat_hit  = sum[DATA_WIDTH];
  end
`endif

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bytes_d    = bytes_q;
    word_d     = word_q;
    sweep_d    = sweep_q;
    count_d    = count_q;
    sat_d      = sat_q;
    upd_ready  = 1'b0;
    sram_req   = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    clear_busy = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // rst_done_q holds upd_ready low until the first cycle after reset release.
        if (rst_done_q) begin
          if (clear_start) begin
            state_d = S_CLR;
            sweep_d = '0;
          end else begin
            upd_ready = 1'b1;
            if (upd_valid) begin
              addr_d  = upd_id[ADDR_WIDTH-1:0];
              bytes_d = upd_bytes;
              state_d = S_RD_REQ;
            end
          end
        end
      end
      S_RD_REQ: begin
        sram_req  = 1'b1;
        sram_addr = addr_q;
        if (sram_gnt) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (sram_rvalid) begin
          word_d  = new_word;
          sat_d   = sat_q | sat_hit;
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        sram_req   = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = addr_q;
        sram_wdata = word_q;
        if (sram_gnt) begin
          count_d = count_q + 32'd1;
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        clear_busy = 1'b1;
        sram_req   = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = sweep_q;
        if (sram_gnt) begin
          if (sweep_q == {ADDR_WIDTH{1'b1}}) state_d = S_IDLE;
          else                               sweep_d = sweep_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      bytes_q    <= '0;
      word_q     <= '0;
      sweep_q    <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bytes_q    <= bytes_d;
      word_q     <= word_d;
      sweep_q    <= sweep_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
      rst_done_q <= 1'b1;
    end
  end

  assign upd_count = count_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_sketch_sram_update.sv
// Directed bench for sketch_sram_update with a small SRAM responder (programmable grant and read latency).
module tb_sketch_sram_update;
  localparam int AW = 4;
  localparam int DW = 32;

`ifdef SKETCH_PKT_CNT_EN
  localparam logic [31:0] EXP_BASIC = 32'h0010_0040;
  localparam logic [31:0] EXP_B2B_1 = 32'h0010_0064;
  localparam logic [31:0] EXP_B2B_2 = 32'h0020_012C;
  localparam logic [31:0] EXP_SAT2  = 32'h0010_0001;
  localparam logic [31:0] EXP_CLRUP = 32'h0010_0008;
  localparam logic [31:0] EXP_STALL = 32'h0010_0005;
`else
  localparam logic [31:0] EXP_BASIC = 32'd64;
  localparam logic [31:0] EXP_B2B_1 = 32'd100;
  localparam logic [31:0] EXP_B2B_2 = 32'd300;
  localparam logic [31:0] EXP_SAT2  = 32'd1;
  localparam logic [31:0] EXP_CLRUP = 32'd8;
  localparam logic [31:0] EXP_STALL = 32'd5;
`endif

  logic          axi_aclk = 1'b0;
  logic          axi_aresetn, upd_valid, upd_ready, clear_start, clear_busy;
  logic          sram_req, sram_we, sram_gnt, sat_flag;
  logic          sram_rvalid = 1'b0;
  logic [15:0]   upd_id, upd_bytes;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [31:0]   upd_count;

  int n_checks = 0;
  int n_fail = 0;

  // SRAM responder state
  logic          gnt_allow, wipe, poke;
  int            rd_lat;
  logic [AW-1:0] poke_addr;
  logic [DW-1:0] poke_data;
  logic [DW-1:0] mem [16];
  int            rd_pend = 0;
  logic [AW-1:0] rd_addr_q = '0;
  int            cyc = 0, n_rd = 0, n_wr = 0, n_hs = 0, hs_cyc = 0, wr_cyc = 0;
  logic [AW-1:0] wr_addr_log [64];
  logic [DW-1:0] wr_data_log [64];

  always #5 axi_aclk = ~axi_aclk;

  assign sram_gnt = sram_req & gnt_allow;

  sketch_sram_update #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .axi_aclk   (axi_aclk),
    .axi_aresetn(axi_aresetn),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_id     (upd_id),
    .upd_bytes  (upd_bytes),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .sram_req   (sram_req),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_gnt   (sram_gnt),
    .sram_rdata (sram_rdata),
    .sram_rvalid(sram_rvalid),
    .upd_count  (upd_count),
    .sat_flag   (sat_flag)
  );

  always @(posedge axi_aclk) begin
    cyc         <= cyc + 1;
    sram_rvalid <= 1'b0;
    if (wipe) for (int i = 0; i < 16; i++) mem[i] <= '0;
    if (poke) mem[poke_addr] <= poke_data;
    if (sram_req && sram_gnt && sram_we) begin
      mem[sram_addr]          <= sram_wdata;
      wr_addr_log[n_wr % 64]  <= sram_addr;
      wr_data_log[n_wr % 64]  <= sram_wdata;
      n_wr                    <= n_wr + 1;
      wr_cyc                  <= cyc;
    end
    if (sram_req && sram_gnt && !sram_we) begin
      n_rd      <= n_rd + 1;
      rd_addr_q <= sram_addr;
      if (rd_lat <= 1) begin
        sram_rvalid <= 1'b1;
        sram_rdata  <= mem[sram_addr];
        rd_pend     <= 0;
      end else begin
        rd_pend <= rd_lat - 1;
      end
    end else if (rd_pend > 0) begin
      rd_pend <= rd_pend - 1;
      if (rd_pend == 1) begin
        sram_rvalid <= 1'b1;
        sram_rdata  <= mem[rd_addr_q];
      end
    end
    if (upd_valid && upd_ready) begin
      n_hs   <= n_hs + 1;
      hs_cyc <= cyc;
    end
  end

  task automatic wait_hs(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge axi_aclk);
      if (n_hs >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_wr(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge axi_aclk);
      if (n_wr >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_update(input logic [15:0] id, input logic [15:0] bytes, output bit ok);
    int  w0;
    bit  ok_h, ok_w;
    w0 = n_wr;
    @(negedge axi_aclk);
    upd_valid = 1'b1; upd_id = id; upd_bytes = bytes;
    wait_hs(n_hs + 1, ok_h);
    upd_valid = 1'b0;
    wait_wr(w0 + 1, ok_w);
    ok = ok_h & ok_w;
  endtask

  task automatic test_reset;
    axi_aresetn = 1'b0; upd_valid = 1'b0; clear_start = 1'b0; upd_id = '0; upd_bytes = '0;
    gnt_allow = 1'b1; rd_lat = 1; wipe = 1'b1; poke = 1'b0; poke_addr = '0; poke_data = '0;
    repeat (3) @(negedge axi_aclk);
    wipe = 1'b0;
    n_checks++;
    if ({upd_ready, sram_req, sram_we, clear_busy, sat_flag} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {upd_ready, sram_req, sram_we, clear_busy, sat_flag});
    end
    n_checks++;
    if (sram_addr !== 4'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", sram_addr); end
    n_checks++;
    if (sram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", sram_wdata); end
    n_checks++;
    if (upd_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", upd_count); end
    axi_aresetn = 1'b1;
    #1;
    n_checks++;
    if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b expected 0", upd_ready); end
    @(negedge axi_aclk);
    n_checks++;
    if (upd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b expected 1", upd_ready); end
  endtask

  task automatic test_basic;
    int w0, r0;
    bit ok;
    w0 = n_wr; r0 = n_rd;
    run_update(16'h0003, 16'd64, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: got %b expected 1", ok); end
    n_checks++;
    if (wr_addr_log[w0 % 64] !== 4'd3) begin n_fail++; $display("FAIL basic_addr: got %h expected 3", wr_addr_log[w0 % 64]); end
    n_checks++;
    if (wr_data_log[w0 % 64] !== EXP_BASIC) begin n_fail++; $display("FAIL basic_data: got %h expected %h", wr_data_log[w0 % 64], EXP_BASIC); end
    // handshake edge plus three: write grant lands in the fourth cycle
    n_checks++;
    if (wr_cyc - hs_cyc !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", wr_cyc - hs_cyc); end
    n_checks++;
    if (n_rd - r0 !== 1) begin n_fail++; $display("FAIL basic_reads: got %0d expected 1", n_rd - r0); end
    n_checks++;
    if (upd_count !== 32'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", upd_count); end
    n_checks++;
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b expected 0", sat_flag); end
  endtask

  task automatic test_back_to_back;
    int h0, w0, h1;
    bit ok1, ok2, ok3;
    @(negedge axi_aclk); wipe = 1'b1;
    @(negedge axi_aclk); wipe = 1'b0;
    h0 = n_hs; w0 = n_wr;
    upd_valid = 1'b1; upd_id = 16'h0013; upd_bytes = 16'd100;
    wait_hs(h0 + 1, ok1);
    h1 = hs_cyc;
    upd_bytes = 16'd200;
    n_checks++;
    if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_between: got %b expected 0", upd_ready); end
    wait_hs(h0 + 2, ok2);
    upd_valid = 1'b0;
    n_checks++;
    if (hs_cyc - h1 !== 4) begin n_fail++; $display("FAIL b2b_hs_spacing: got %0d expected 4", hs_cyc - h1); end
    wait_wr(w0 + 2, ok3);
    n_checks++;
    if ((ok1 & ok2 & ok3) !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout: got %b%b%b expected 111", ok1, ok2, ok3); end
    n_checks++;
    if (wr_data_log[w0 % 64] !== EXP_B2B_1) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", wr_data_log[w0 % 64], EXP_B2B_1); end
    n_checks++;
    if ({wr_addr_log[(w0 + 1) % 64], wr_data_log[(w0 + 1) % 64]} !== {4'd3, EXP_B2B_2}) begin
      n_fail++; $display("FAIL b2b_second: got %h/%h expected 3/%h", wr_addr_log[(w0 + 1) % 64], wr_data_log[(w0 + 1) % 64], EXP_B2B_2);
    end
    n_checks++;
    if (upd_count !== 32'd3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", upd_count); end
  endtask

  task automatic test_saturate;
    bit ok;
    @(negedge axi_aclk); poke = 1'b1; poke_addr = 4'd5; poke_data = 32'hFFFF_FF00;
    @(negedge axi_aclk); poke = 1'b0;
    n_checks++;
    if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_before: got %b expected 0", sat_flag); end
    run_update(16'h0005, 16'h0200, ok);
    n_checks++;
    if ({ok, wr_data_log[(n_wr - 1) % 64]} !== {1'b1, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL sat_word: got %b/%h expected 1/ffffffff", ok, wr_data_log[(n_wr - 1) % 64]);
    end
    n_checks++;
    if (sat_flag !== 1'b1) begin n_fail++; $display("FAIL sat_set: got %b expected 1", sat_flag); end
    run_update(16'h0006, 16'd1, ok);
    n_checks++;
    if ({ok, wr_data_log[(n_wr - 1) % 64]} !== {1'b1, EXP_SAT2}) begin
      n_fail++; $display("FAIL sat_next_word: got %b/%h expected 1/%h", ok, wr_data_log[(n_wr - 1) % 64], EXP_SAT2);
    end
    n_checks++;
    if ({sat_flag, upd_count} !== {1'b1, 32'd5}) begin n_fail++; $display("FAIL sat_sticky: got %b/%0d expected 1/5", sat_flag, upd_count); end
  endtask

  task automatic test_clear;
    int h0, w0, bad, waited;
    bit ok_h, ok_w;
    h0 = n_hs; w0 = n_wr;
    @(negedge axi_aclk);
    clear_start = 1'b1; upd_valid = 1'b1; upd_id = 16'h0007; upd_bytes = 16'd8;
    #1;
    n_checks++;
    if (upd_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_same_cycle: got %b expected 0", upd_ready); end
    @(negedge axi_aclk);
    clear_start = 1'b0;
    n_checks++;
    if (clear_busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_set: got %b expected 1", clear_busy); end
    waited = 0;
    while (clear_busy === 1'b1 && waited < 40) begin
      @(negedge axi_aclk);
      waited++;
    end
    n_checks++;
    if (clear_busy !== 1'b0) begin n_fail++; $display("FAIL clr_timeout: got busy %b expected 0", clear_busy); end
    n_checks++;
    if (n_hs - h0 !== 0) begin n_fail++; $display("FAIL clr_no_handshake: got %0d expected 0", n_hs - h0); end
    n_checks++;
    if (n_wr - w0 !== 16) begin n_fail++; $display("FAIL clr_write_count: got %0d expected 16", n_wr - w0); end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (wr_addr_log[(w0 + i) % 64] !== AW'(i) || wr_data_log[(w0 + i) % 64] !== 32'h0) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL clr_sweep_order: got %0d bad writes expected 0", bad); end
    n_checks++;
    if ({upd_count, sat_flag, upd_ready} !== {32'd5, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL clr_state_kept: got %0d/%b/%b expected 5/1/1", upd_count, sat_flag, upd_ready);
    end
    wait_hs(h0 + 1, ok_h);
    upd_valid = 1'b0;
    wait_wr(w0 + 17, ok_w);
    n_checks++;
    if ({ok_h, ok_w, wr_addr_log[(w0 + 16) % 64], wr_data_log[(w0 + 16) % 64]} !== {2'b11, 4'd7, EXP_CLRUP}) begin
      n_fail++; $display("FAIL clr_then_update: got %b%b/%h/%h expected 11/7/%h", ok_h, ok_w,
                         wr_addr_log[(w0 + 16) % 64], wr_data_log[(w0 + 16) % 64], EXP_CLRUP);
    end
  endtask

  task automatic test_stall;
    int w0, r0, bad, busy_seen;
    bit ok_h, ok_w;
    w0 = n_wr; r0 = n_rd; bad = 0; busy_seen = 0;
    gnt_allow = 1'b0; rd_lat = 7;
    @(negedge axi_aclk);
    upd_valid = 1'b1; upd_id = 16'h0009; upd_bytes = 16'd5;
    wait_hs(n_hs + 1, ok_h);
    upd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({sram_req, sram_we, sram_addr} !== {2'b10, 4'd9}) bad++;
      clear_start = (i == 2);
      @(negedge axi_aclk);
    end
    clear_start = 1'b0;
    if ({sram_req, sram_we, sram_addr} !== {2'b10, 4'd9}) bad++;
    gnt_allow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge axi_aclk);
      if (sram_req !== 1'b0) bad++;
      if (clear_busy === 1'b1) busy_seen++;
    end
    wait_wr(w0 + 1, ok_w);
    n_checks++;
    if ({ok_h, ok_w} !== 2'b11) begin n_fail++; $display("FAIL stall_timeout: got %b%b expected 11", ok_h, ok_w); end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL stall_req_stable: got %0d bad samples expected 0", bad); end
    n_checks++;
    if (busy_seen !== 0) begin n_fail++; $display("FAIL stall_clear_ignored: got %0d busy cycles expected 0", busy_seen); end
    n_checks++;
    if ({n_rd - r0, n_wr - w0} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL stall_single_rw: got %0d/%0d expected 1/1", n_rd - r0, n_wr - w0); end
    n_checks++;
    if ({wr_addr_log[w0 % 64], wr_data_log[w0 % 64]} !== {4'd9, EXP_STALL}) begin
      n_fail++; $display("FAIL stall_word: got %h/%h expected 9/%h", wr_addr_log[w0 % 64], wr_data_log[w0 % 64], EXP_STALL);
    end
    n_checks++;
    if (upd_count !== 32'd7) begin n_fail++; $display("FAIL stall_count: got %0d expected 7", upd_count); end
  endtask

  task automatic test_reset_mid;
    int w0, r0;
    bit ok_h;
    w0 = n_wr; r0 = n_rd;
    gnt_allow = 1'b1; rd_lat = 6;
    @(negedge axi_aclk);
    upd_valid = 1'b1; upd_id = 16'h000A; upd_bytes = 16'd3;
    wait_hs(n_hs + 1, ok_h);
    upd_valid = 1'b0;
    @(negedge axi_aclk);
    n_checks++;
    if ({ok_h, n_rd - r0} !== {1'b1, 32'd1}) begin n_fail++; $display("FAIL rstmid_in_rd_wait: got %b/%0d expected 1/1", ok_h, n_rd - r0); end
    axi_aresetn = 1'b0;
    @(negedge axi_aclk);
    n_checks++;
    if ({upd_ready, sram_req, sram_we, clear_busy, sat_flag, sram_addr, sram_wdata, upd_count} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b%b%b%b%b/%h/%h/%0d expected all zero",
                         upd_ready, sram_req, sram_we, clear_busy, sat_flag, sram_addr, sram_wdata, upd_count);
    end
    axi_aresetn = 1'b1;
    repeat (10) @(negedge axi_aclk);
    n_checks++;
    if (n_wr - w0 !== 0) begin n_fail++; $display("FAIL rstmid_no_write: got %0d writes expected 0", n_wr - w0); end
    n_checks++;
    if ({upd_ready, sram_req, upd_count} !== {2'b10, 32'd0}) begin
      n_fail++; $display("FAIL rstmid_idle_after: got %b%b/%0d expected 10/0", upd_ready, sram_req, upd_count);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_saturate;
    test_clear;
    test_stall;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
